// File: rtl/id_pb8_control_unit_if.sv
// Bus between the put-block-8x8 control unit, its block producer, its
// raster consumer and the two ping-pong strip buffers.
//
// Handshakes:
//   write side - a block word moves on every clock edge where
//     PB8_inputready=1 and PB8_stall=0; while PB8_stall=1 the producer holds
//     its word and it is not consumed.
//   read side  - a raster read issues on every clock edge where the read
//     buffer is full and PB8_outputenable=1; the RAM data on the MUX2 path
//     is valid one cycle later, flagged by PB8_outputready.
interface id_pb8_control_unit_if #(
  parameter int ADDR_W = 13
);
  logic              PB8_inputready;
  logic [15:0]       ID_X_image;
  logic              PB8_outputenable;
  logic              PB8_stall;
  logic              PB8_outputready;
  logic              PB8_strip_done;
  logic              MUX1_select;
  logic              MUX2_select;
  logic              buffer0_wren;
  logic              buffer1_wren;
  logic [ADDR_W-1:0] buffer0_address;
  logic [ADDR_W-1:0] buffer1_address;
  // bit0 = buffer0 full, bit1 = buffer1 full
  logic [1:0]        buf_state_dbg;

  modport master (
    output PB8_inputready, ID_X_image, PB8_outputenable,
    input  PB8_stall, PB8_outputready, PB8_strip_done, MUX1_select,
           MUX2_select, buffer0_wren, buffer1_wren, buffer0_address,
           buffer1_address, buf_state_dbg
  );

  modport slave (
    input  PB8_inputready, ID_X_image, PB8_outputenable,
    output PB8_stall, PB8_outputready, PB8_strip_done, MUX1_select,
           MUX2_select, buffer0_wren, buffer1_wren, buffer0_address,
           buffer1_address, buf_state_dbg
  );
endinterface

// File: rtl/id_pb8_control_unit.sv
// Put-block-8x8 control unit: scatters 8x8 block words into raster order
// inside two ping-pong strip buffers and drains each full strip linearly.
module id_pb8_control_unit #(
  parameter int ADDR_W = 13
) (
  input logic                   clk,
  input logic                   reset_n,
  id_pb8_control_unit_if.slave  bus
);

  typedef enum logic {
    BUF_EMPTY = 1'b0,
    BUF_FULL  = 1'b1
  } buf_state_e;

  // Geometry derived from the image width (X*3 words of 8 bits per row)
  logic [15:0]       x3;
  logic [15:0]       blocks_m1;
  logic [ADDR_W-1:0] stride;
  logic [ADDR_W-1:0] strip_n;

  assign x3        = {bus.ID_X_image[14:0], 1'b0} + bus.ID_X_image;
  assign stride    = ADDR_W'(x3 >> 2);
  assign blocks_m1 = (x3 >> 3) - 16'd1;
  assign strip_n   = ADDR_W'({x3, 1'b0});

  buf_state_e        state0_q, state1_q, state0_d, state1_d;
  logic              wsel_q, rsel_q;
  logic              h_q;
  logic [2:0]        r_q;
  logic [15:0]       b_q;
  logic [ADDR_W-1:0] row_base_q;
  logic [ADDR_W-1:0] rcount_q;
  logic [ADDR_W-1:0] waddr;
  logic              oready_q, done_q, mux2_q;

  logic wr_full, rd_full, accept, last_wr, rd_issue, last_rd;

  // wsel/rsel = 1 selects buffer0
  assign wr_full  = wsel_q ? (state0_q == BUF_FULL) : (state1_q == BUF_FULL);
  assign rd_full  = rsel_q ? (state0_q == BUF_FULL) : (state1_q == BUF_FULL);
  // Reset gates the accept so write enables read 0 the instant reset asserts
  assign accept   = bus.PB8_inputready & ~wr_full & reset_n;
  assign last_wr  = accept & h_q & (r_q == 3'd7) & (b_q == blocks_m1);
  assign rd_issue = rd_full & bus.PB8_outputenable;
  assign last_rd  = rd_issue & (rcount_q == strip_n - ADDR_W'(1));

  // Raster address of the current block word: r*S + 2*b + h
  assign waddr = row_base_q + {b_q[ADDR_W-2:0], 1'b0} + ADDR_W'(h_q);

  // Buffer state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state0_q <= BUF_EMPTY;
      state1_q <= BUF_EMPTY;
    end else begin
      state0_q <= state0_d;
      state1_q <= state1_d;
    end
  end

  // Buffer next state: fill completes on the last write, drain on the last read
  always_comb begin
    state0_d = state0_q;
    state1_d = state1_q;
    if (last_wr) begin
      if (wsel_q) state0_d = BUF_FULL;
      else        state1_d = BUF_FULL;
    end
    if (last_rd) begin
      if (rsel_q) state0_d = BUF_EMPTY;
      else        state1_d = BUF_EMPTY;
    end
  end

  // Write-side counters: half, row, block and the r*S row accumulator
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wsel_q     <= 1'b1;
      h_q        <= 1'b0;
      r_q        <= 3'd0;
      b_q        <= 16'd0;
      row_base_q <= '0;
    end else if (last_wr) begin
      wsel_q     <= ~wsel_q;
      h_q        <= 1'b0;
      r_q        <= 3'd0;
      b_q        <= 16'd0;
      row_base_q <= '0;
    end else if (accept) begin
      h_q <= ~h_q;
      if (h_q) begin
        r_q <= r_q + 3'd1;
        if (r_q == 3'd7) begin
          row_base_q <= '0;
          b_q        <= (b_q == blocks_m1) ? 16'd0 : b_q + 16'd1;
        end else begin
          row_base_q <= row_base_q + stride;
        end
      end
    end
  end

  // Read-side linear counter and read pointer
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsel_q   <= 1'b1;
      rcount_q <= '0;
    end else if (rd_issue) begin
      if (last_rd) begin
        rcount_q <= '0;
        rsel_q   <= ~rsel_q;
      end else begin
        rcount_q <= rcount_q + ADDR_W'(1);
      end
    end
  end

  // Read status delayed to line up with the RAM's one-cycle read latency
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      oready_q <= 1'b0;
      done_q   <= 1'b0;
      mux2_q   <= 1'b1;
    end else begin
      oready_q <= rd_issue;
      done_q   <= last_rd;
      mux2_q   <= rsel_q;
    end
  end

  assign bus.PB8_stall       = wr_full;
  assign bus.PB8_outputready = oready_q;
  assign bus.PB8_strip_done  = done_q;
  assign bus.MUX1_select     = wsel_q;
  assign bus.MUX2_select     = mux2_q;
  assign bus.buffer0_wren    = accept & wsel_q;
  assign bus.buffer1_wren    = accept & ~wsel_q;
  // A buffer being read is FULL, so it can never also be the write target
  assign bus.buffer0_address = (rsel_q && state0_q == BUF_FULL) ? rcount_q : waddr;
  assign bus.buffer1_address = (!rsel_q && state1_q == BUF_FULL) ? rcount_q : waddr;
  assign bus.buf_state_dbg   = {state1_q == BUF_FULL, state0_q == BUF_FULL};

endmodule

// File: tb/tb_id_pb8_control_unit.sv
// Bench for id_pb8_control_unit: word-count model of the ping-pong strip
// buffers, per-cycle output compare, raster-order scoreboard, directed tests.
module tb_id_pb8_control_unit;
  localparam int ADDR_W = 13;
  localparam int DEPTH  = 1 << ADDR_W;

  // ---------------- clock / reset ----------------
  logic clk     = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  id_pb8_control_unit_if #(.ADDR_W(ADDR_W)) bus ();
  id_pb8_control_unit #(.ADDR_W(ADDR_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d @%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Where strip word n (block n/16, word n%16) lands in raster order
  function automatic int model_waddr(input int x, input int n);
    int s;
    int k;
    s = x * 3 / 4;
    k = n % 16;
    return (k / 2) * s + 2 * (n / 16) + (k % 2);
  endfunction

  // Which strip word sits at raster position p
  function automatic int raster_word(input int x, input int p);
    int s;
    int c;
    s = x * 3 / 4;
    c = p % s;
    return (c / 2) * 16 + (p / s) * 2 + (c % 2);
  endfunction

  function automatic int strip_words(input int x);
    return (x * 6) % DEPTH;
  endfunction

  bit  m_full [2] = '{1'b0, 1'b0};
  int  m_wbuf = 0, m_rbuf = 0, m_wcnt = 0, m_rcnt = 0;
  int  acc_total = 0, strip_start = 0;
  bit  m_oready = 0, m_done = 0, m_mux2 = 1;
  logic [31:0] exp_q[$];
  int  pend_tag = 0;
  int  mem0 [DEPTH];
  int  mem1 [DEPTH];

  // Model state advances on each clock edge from the inputs of that cycle
  initial forever begin
    @(posedge clk or negedge reset_n);
    if (!reset_n) begin
      m_full = '{1'b0, 1'b0};
      m_wbuf = 0; m_rbuf = 0; m_wcnt = 0; m_rcnt = 0;
      m_oready = 0; m_done = 0; m_mux2 = 1;
      exp_q.delete();
    end else begin
      int n;
      bit acc;
      bit rd;
      n   = strip_words(int'(bus.ID_X_image));
      acc = bus.PB8_inputready && !m_full[m_wbuf];
      rd  = m_full[m_rbuf] && bus.PB8_outputenable;
      m_oready = rd;
      m_done   = rd && (m_rcnt == n - 1);
      m_mux2   = (m_rbuf == 0);
      if (rd) begin
        if (m_rcnt == n - 1) begin
          m_rcnt = 0;
          m_full[m_rbuf] = 0;
          m_rbuf = 1 - m_rbuf;
        end else begin
          m_rcnt++;
        end
      end
      if (acc) begin
        if (m_wcnt == 0) strip_start = acc_total;
        acc_total++;
        if (m_wcnt == n - 1) begin
          for (int p = 0; p < n; p++)
            exp_q.push_back(32'(strip_start + raster_word(int'(bus.ID_X_image), p)));
          m_full[m_wbuf] = 1;
          m_wbuf = 1 - m_wbuf;
          m_wcnt = 0;
        end else begin
          m_wcnt++;
        end
      end
    end
  end

  // ---------------- compare process + scoreboard ----------------
  initial forever begin
    @(negedge clk);
    if (reset_n) begin
      int  x;
      int  wa;
      int  a0;
      int  a1;
      bit  st;
      bit  acc;
      x   = int'(bus.ID_X_image);
      st  = m_full[m_wbuf];
      acc = bus.PB8_inputready && !st;
      wa  = model_waddr(x, m_wcnt);
      a0  = (m_rbuf == 0 && m_full[0]) ? m_rcnt : wa;
      a1  = (m_rbuf == 1 && m_full[1]) ? m_rcnt : wa;
      check("stall",  bus.PB8_stall, st);
      check("wren0",  bus.buffer0_wren, acc && m_wbuf == 0);
      check("wren1",  bus.buffer1_wren, acc && m_wbuf == 1);
      check("addr0",  bus.buffer0_address, a0);
      check("addr1",  bus.buffer1_address, a1);
      check("mux1",   bus.MUX1_select, m_wbuf == 0);
      check("mux2",   bus.MUX2_select, m_mux2);
      check("oready", bus.PB8_outputready, m_oready);
      check("done",   bus.PB8_strip_done, m_done);
      if (m_oready) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL rd_extra actual=%0d required=none", pend_tag);
        end else begin
          check("rd_order", pend_tag, exp_q.pop_front());
        end
      end
      if (bus.buffer0_wren) mem0[bus.buffer0_address] = acc_total;
      if (bus.buffer1_wren) mem1[bus.buffer1_address] = acc_total;
      if (m_full[m_rbuf] && bus.PB8_outputenable)
        pend_tag = (m_rbuf == 0) ? mem0[bus.buffer0_address] : mem1[bus.buffer1_address];
    end
  end

  // ---------------- driver tasks ----------------
  logic [31:0] wr_log[$];

  // Called at posedge+1; streams count accepted words, logging their addresses
  task automatic push(input int count, input bit rnd);
    int got = 0;
    int cyc = 0;
    wr_log.delete();
    bus.PB8_inputready = 1'b1;
    while (got < count && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      if (!bus.PB8_stall) begin
        got++;
        wr_log.push_back(bus.buffer0_wren ? 32'(bus.buffer0_address) : 32'(bus.buffer1_address));
      end
      @(posedge clk); #1;
      if (rnd) bus.PB8_outputenable = 1'($urandom_range(0, 1));
    end
    bus.PB8_inputready = 1'b0;
    if (got < count) begin
      total++; bad++;
      $display("FAIL push_timeout actual=%0d required=%0d", got, count);
    end
  endtask

  // Reads until both buffers are empty and every expected word has come out
  task automatic drain(input bit rnd, output int pulses);
    int cyc = 0;
    pulses = 0;
    while ((m_full[0] || m_full[1] || m_oready || exp_q.size() != 0) && cyc < 5000) begin
      @(posedge clk); #1;
      bus.PB8_outputenable = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (bus.PB8_strip_done) pulses++;
      cyc++;
    end
    if (cyc >= 5000) begin
      total++; bad++;
      $display("FAIL drain_timeout actual=%0d required=0", exp_q.size());
    end
    @(posedge clk); #1;
    bus.PB8_outputenable = 1'b0;
  endtask

  task automatic do_reset(input int x);
    @(posedge clk); #2;
    reset_n = 1'b0;
    bus.PB8_inputready   = 1'b0;
    bus.PB8_outputenable = 1'b0;
    bus.ID_X_image       = 16'(x);
    repeat (2) @(posedge clk);
    @(negedge clk); #2;
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_stall"},  bus.PB8_stall, 0);
    check({tag, "_wren0"},  bus.buffer0_wren, 0);
    check({tag, "_wren1"},  bus.buffer1_wren, 0);
    check({tag, "_addr0"},  bus.buffer0_address, 0);
    check({tag, "_addr1"},  bus.buffer1_address, 0);
    check({tag, "_oready"}, bus.PB8_outputready, 0);
    check({tag, "_done"},   bus.PB8_strip_done, 0);
    check({tag, "_mux1"},   bus.MUX1_select, 1);
    check({tag, "_mux2"},   bus.MUX2_select, 1);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int  pulses;
    bit  found;
    bit  prev_stall;
    bus.PB8_inputready   = 1'b0;
    bus.PB8_outputenable = 1'b0;
    bus.ID_X_image       = 16'd8;
    #2 reset_n = 1'b0;
    #1 check_reset_values("reset");

    // Pin the model against hand-derived addresses
    check("model_w0",   model_waddr(8, 0), 0);
    check("model_w2",   model_waddr(8, 2), 6);
    check("model_w3",   model_waddr(8, 3), 7);
    check("model_w16",  model_waddr(8, 16), 2);
    check("model_w47",  model_waddr(8, 47), 47);
    check("model_x16",  model_waddr(16, 83), 23);
    check("model_r2",   raster_word(8, 2), 16);
    check("model_r6",   raster_word(8, 6), 2);
    check("model_n8",   strip_words(8), 48);

    repeat (2) @(posedge clk);
    @(negedge clk); #2 reset_n = 1'b1;
    @(posedge clk); #1;

    // One X=8 strip into buffer0, then drain it
    push(48, 1'b0);
    check("fill_a1",   wr_log[1], 1);
    check("fill_a2",   wr_log[2], 6);
    check("fill_a3",   wr_log[3], 7);
    check("fill_blk1", wr_log[16], 2);
    check("fill_last", wr_log[47], 47);
    @(negedge clk);
    check("fill_mux1", bus.MUX1_select, 0);
    check("fill_dbg",  bus.buf_state_dbg, 1);
    @(posedge clk); #1;
    drain(1'b0, pulses);
    check("drain_pulses", pulses, 1);
    @(negedge clk);
    check("drain_dbg", bus.buf_state_dbg, 0);
    @(posedge clk); #1;

    // Both strips fill, the 97th word stalls until strip 0 drains
    do_reset(8);
    push(96, 1'b0);
    bus.PB8_inputready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("full_stall", bus.PB8_stall, 1);
      check("full_wren0", bus.buffer0_wren, 0);
      check("full_wren1", bus.buffer1_wren, 0);
    end
    @(posedge clk); #1;
    bus.PB8_outputenable = 1'b1;
    found = 0;
    prev_stall = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (bus.buffer0_wren || bus.buffer1_wren) found = 1;
      else prev_stall = bus.PB8_stall;
    end
    if (!found) begin
      total++; bad++;
      $display("FAIL resume_timeout actual=0 required=1");
    end else begin
      check("resume_wren0",  bus.buffer0_wren, 1);
      check("resume_addr0",  bus.buffer0_address, 0);
      check("resume_done",   bus.PB8_strip_done, 1);
      check("resume_prevst", prev_stall, 1);
    end
    @(posedge clk); #1;

    // Keep writing while the other buffer drains under a random enable
    push(47, 1'b1);
    push(48, 1'b1);
    drain(1'b1, pulses);

    // X=16: block 5 word 3 lands at 12+10+1
    do_reset(16);
    push(84, 1'b0);
    check("x16_addr", wr_log[83], 23);
    check("x16_blk1", wr_log[16], 2);

    // Reset in the middle of a strip
    do_reset(8);
    push(20, 1'b0);
    bus.PB8_inputready   = 1'b1;
    bus.PB8_outputenable = 1'b1;
    @(posedge clk); #3;
    reset_n = 1'b0;
    #1 check_reset_values("midrst");
    repeat (2) @(posedge clk);
    @(negedge clk); #2;
    reset_n = 1'b1;
    #1;
    check("after_rst_wren0", bus.buffer0_wren, 1);
    check("after_rst_addr0", bus.buffer0_address, 0);
    @(posedge clk); #1;
    bus.PB8_inputready   = 1'b0;
    bus.PB8_outputenable = 1'b0;
    repeat (3) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog
  initial begin
    #900000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
